// File: rtl/weight_update_pkg.sv
// weight_update_pkg
// Shared configuration, types and saturating arithmetic helpers for the
// dc_dw weight-update block.
//   DATA_SIZE      : width of one signed fixed-point element
//   SIZE           : lanes per row and rows per layer matrix
//   MAX_LAYER_SIZE : number of layers held in the stores
//   LR_SHIFT       : arithmetic right shift applied to gradients
//   CLIP_LIMIT     : incoming-lane bound, used only with DC_DW_GRAD_CLIP_EN
package weight_update_pkg;

    localparam int DATA_SIZE      = 8;
    localparam int SIZE           = 3;
    localparam int MAX_LAYER_SIZE = 4;
    localparam int LR_SHIFT       = 3;
    localparam int CLIP_LIMIT     = 32;

    localparam int IDX_W    = 33;
    localparam int LAYER_W  = $clog2(MAX_LAYER_SIZE);
    localparam int ROW_W    = $clog2(SIZE);
    localparam int ROW_BITS = DATA_SIZE * SIZE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    typedef logic signed [DATA_SIZE-1:0] row_t [SIZE];

    // One guard bit catches overflow: sign and guard disagree only on overflow.
    function automatic logic signed [DATA_SIZE-1:0] sat_add(
        input logic signed [DATA_SIZE-1:0] a,
        input logic signed [DATA_SIZE-1:0] b
    );
        logic [DATA_SIZE:0] sum;
        sum = {a[DATA_SIZE-1], a} + {b[DATA_SIZE-1], b};
        if (sum[DATA_SIZE] != sum[DATA_SIZE-1]) begin
            sat_add = sum[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                     : {1'b0, {(DATA_SIZE-1){1'b1}}};
        end else begin
            sat_add = sum[DATA_SIZE-1:0];
        end
    endfunction

    function automatic logic signed [DATA_SIZE-1:0] sat_sub(
        input logic signed [DATA_SIZE-1:0] a,
        input logic signed [DATA_SIZE-1:0] b
    );
        logic [DATA_SIZE:0] diff;
        diff = {a[DATA_SIZE-1], a} - {b[DATA_SIZE-1], b};
        if (diff[DATA_SIZE] != diff[DATA_SIZE-1]) begin
            sat_sub = diff[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                      : {1'b0, {(DATA_SIZE-1){1'b1}}};
        end else begin
            sat_sub = diff[DATA_SIZE-1:0];
        end
    endfunction

    // Bound an incoming gradient lane to [-CLIP_LIMIT, CLIP_LIMIT].
    function automatic logic signed [DATA_SIZE-1:0] clip_lane(
        input logic signed [DATA_SIZE-1:0] x
    );
        logic signed [DATA_SIZE-1:0] hi;
        logic signed [DATA_SIZE-1:0] lo;
        hi = DATA_SIZE'(CLIP_LIMIT);
        lo = -hi;
        if (x > hi) begin
            clip_lane = hi;
        end else if (x < lo) begin
            clip_lane = lo;
        end else begin
            clip_lane = x;
        end
    endfunction

    // Lane g occupies bits [(SIZE-g)*DATA_SIZE-1 -: DATA_SIZE], lane 0 at the top.
    function automatic logic [ROW_BITS-1:0] pack_row(input row_t row);
        pack_row = '0;
        for (int g = 0; g < SIZE; g++) begin
            pack_row[(SIZE-g)*DATA_SIZE-1 -: DATA_SIZE] = row[g];
        end
    endfunction

endpackage

// File: rtl/dc_dw_weight_update_if.sv
// dc_dw_weight_update_if
// Bundles the gradient stream, control pulses and weight readout of the
// weight-update block.
//   master : producer side (drives gradient rows, commit, weight_read)
//   slave  : weight-update block
interface dc_dw_weight_update_if;
    import weight_update_pkg::*;

    logic [ROW_BITS-1:0] dc_dw_stream;
    logic                dc_dw_valid;
    logic [IDX_W-1:0]    dc_dw_layer_index;
    logic                commit;
    logic                weight_read;
    logic [IDX_W-1:0]    weight_read_layer;
    logic [ROW_BITS-1:0] weight_stream;
    logic                weight_valid;
    logic                busy;
    logic                drop_err;

    modport master (
        output dc_dw_stream, dc_dw_valid, dc_dw_layer_index,
               commit, weight_read, weight_read_layer,
        input  weight_stream, weight_valid, busy, drop_err
    );

    modport slave (
        input  dc_dw_stream, dc_dw_valid, dc_dw_layer_index,
               commit, weight_read, weight_read_layer,
        output weight_stream, weight_valid, busy, drop_err
    );

endinterface

// File: rtl/dc_dw_weight_update_weight_row_alu.sv
// weight_row_alu
// Combinational descent step for one row: w_out = sat(w_in - (grad >>> LR_SHIFT)).
//   weight_in  : current weight row
//   grad_in    : accumulated gradient row
//   weight_out : updated weight row
module weight_row_alu
    import weight_update_pkg::*;
(
    input  row_t weight_in,
    input  row_t grad_in,
    output row_t weight_out
);

    // Per-lane learning-rate scaling followed by a saturating subtract
    always_comb begin
        weight_out = '{default: '0};
        for (int g = 0; g < SIZE; g++) begin
            weight_out[g] = sat_sub(weight_in[g], grad_in[g] >>> LR_SHIFT);
        end
    end

endmodule

// File: rtl/dc_dw_weight_update.sv
// dc_dw_weight_update
// Accumulates per-layer gradient rows, applies gradient descent to an internal
// weight store on commit, and streams a selected layer's weights on request.
// Optional macro DC_DW_GRAD_CLIP_EN clamps each incoming lane to
// [-CLIP_LIMIT, CLIP_LIMIT] before accumulation.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : slave side of dc_dw_weight_update_if (gradient rows, commit,
//           weight_read in; weight_stream, weight_valid, busy, drop_err out)
module dc_dw_weight_update
    import weight_update_pkg::*;
(
    input logic                  clk,
    input logic                  reset,
    dc_dw_weight_update_if.slave bus
);

    state_t              state_r;
    state_t              next_state_s;
    logic [ROW_W-1:0]    row_cnt_r;
    logic [LAYER_W-1:0]  apply_layer_r;
    logic [ROW_W-1:0]    apply_row_r;
    logic [ROW_W-1:0]    read_cnt_r;
    logic [LAYER_W-1:0]  read_layer_r;
    logic [ROW_BITS-1:0] weight_stream_r;
    logic                weight_valid_r;
    logic                busy_r;
    logic                drop_err_r;

    row_t grad_r   [MAX_LAYER_SIZE][SIZE];
    row_t weight_r [MAX_LAYER_SIZE][SIZE];

    row_t lane_in_s;
    row_t alu_weight_s;
    row_t alu_grad_s;
    row_t alu_out_s;

    logic               row_layer_ok_s;
    logic               read_layer_ok_s;
    logic [LAYER_W-1:0] row_layer_s;
    logic               row_advance_s;
    logic               accept_row_s;
    logic               start_apply_s;
    logic               start_read_s;
    logic               drop_s;
    logic               apply_last_s;

    assign row_layer_ok_s  = bus.dc_dw_layer_index < IDX_W'(MAX_LAYER_SIZE);
    assign read_layer_ok_s = bus.weight_read_layer < IDX_W'(MAX_LAYER_SIZE);
    assign row_layer_s     = bus.dc_dw_layer_index[LAYER_W-1:0];
    // Row counter advances on every row seen in IDLE, including dropped ones.
    assign row_advance_s   = (state_r == ST_IDLE) && bus.dc_dw_valid;
    assign apply_last_s    = (apply_layer_r == LAYER_W'(MAX_LAYER_SIZE - 1)) &&
                             (apply_row_r == ROW_W'(SIZE - 1));

    // Unpack the incoming row and optionally clip each lane
    always_comb begin
        lane_in_s = '{default: '0};
        for (int g = 0; g < SIZE; g++) begin
`ifdef DC_DW_GRAD_CLIP_EN
            lane_in_s[g] = clip_lane(bus.dc_dw_stream[(SIZE-g)*DATA_SIZE-1 -: DATA_SIZE]);
`else
            lane_in_s[g] = bus.dc_dw_stream[(SIZE-g)*DATA_SIZE-1 -: DATA_SIZE];
`endif
        end
    end

    // Select the (layer,row) being updated this APPLY cycle
    always_comb begin
        alu_weight_s = weight_r[apply_layer_r][apply_row_r];
        alu_grad_s   = grad_r[apply_layer_r][apply_row_r];
    end

    weight_row_alu u_alu (
        .weight_in  (alu_weight_s),
        .grad_in    (alu_grad_s),
        .weight_out (alu_out_s)
    );

    // Next-state and request arbitration; commit beats a same-cycle weight_read
    always_comb begin
        next_state_s  = state_r;
        accept_row_s  = 1'b0;
        start_apply_s = 1'b0;
        start_read_s  = 1'b0;
        drop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_row_s = bus.dc_dw_valid && row_layer_ok_s;
                if (bus.commit) begin
                    next_state_s  = ST_APPLY;
                    start_apply_s = 1'b1;
                    drop_s        = (bus.dc_dw_valid && !row_layer_ok_s) || bus.weight_read;
                end else if (bus.weight_read) begin
                    drop_s = (bus.dc_dw_valid && !row_layer_ok_s) || !read_layer_ok_s;
                    if (read_layer_ok_s) begin
                        next_state_s = ST_READ;
                        start_read_s = 1'b1;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    drop_s = bus.dc_dw_valid && !row_layer_ok_s;
                end
            end
            ST_APPLY: begin
                drop_s = bus.dc_dw_valid || bus.commit || bus.weight_read;
                if (apply_last_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_APPLY;
                end
            end
            ST_READ: begin
                drop_s = bus.dc_dw_valid || bus.commit || bus.weight_read;
                if (read_cnt_r == ROW_W'(SIZE - 1)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_READ;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, sticky error and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            row_cnt_r       <= '0;
            apply_layer_r   <= '0;
            apply_row_r     <= '0;
            read_cnt_r      <= '0;
            read_layer_r    <= '0;
            weight_stream_r <= '0;
            weight_valid_r  <= 1'b0;
            busy_r          <= 1'b0;
            drop_err_r      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
            if (drop_s) begin
                drop_err_r <= 1'b1;
            end

            if (start_apply_s) begin
                row_cnt_r <= '0;
            end else if (row_advance_s) begin
                row_cnt_r <= (row_cnt_r == ROW_W'(SIZE - 1)) ? '0 : row_cnt_r + 1'b1;
            end

            // apply_layer/apply_row together form the APPLY cycle counter
            if (state_r == ST_APPLY) begin
                if (apply_row_r == ROW_W'(SIZE - 1)) begin
                    apply_row_r   <= '0;
                    apply_layer_r <= (apply_layer_r == LAYER_W'(MAX_LAYER_SIZE - 1)) ?
                                     '0 : apply_layer_r + 1'b1;
                end else begin
                    apply_row_r <= apply_row_r + 1'b1;
                end
            end else begin
                apply_row_r   <= '0;
                apply_layer_r <= '0;
            end

            if (start_read_s) begin
                read_layer_r <= bus.weight_read_layer[LAYER_W-1:0];
            end
            if (state_r == ST_READ) begin
                read_cnt_r      <= read_cnt_r + 1'b1;
                weight_valid_r  <= 1'b1;
                weight_stream_r <= pack_row(weight_r[read_layer_r][read_cnt_r]);
            end else begin
                read_cnt_r      <= '0;
                weight_valid_r  <= 1'b0;
                weight_stream_r <= '0;
            end
        end
    end

    // Gradient accumulation in IDLE and per-row weight update in APPLY
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < MAX_LAYER_SIZE; l++) begin
                for (int r = 0; r < SIZE; r++) begin
                    grad_r[l][r]   <= '{default: '0};
                    weight_r[l][r] <= '{default: '0};
                end
            end
        end else begin
            if (accept_row_s) begin
                for (int g = 0; g < SIZE; g++) begin
                    grad_r[row_layer_s][row_cnt_r][g] <=
                        sat_add(grad_r[row_layer_s][row_cnt_r][g], lane_in_s[g]);
                end
            end
            if (state_r == ST_APPLY) begin
                weight_r[apply_layer_r][apply_row_r] <= alu_out_s;
                grad_r[apply_layer_r][apply_row_r]   <= '{default: '0};
            end
        end
    end

    assign bus.weight_stream = weight_stream_r;
    assign bus.weight_valid  = weight_valid_r;
    assign bus.busy          = busy_r;
    assign bus.drop_err      = drop_err_r;

endmodule

// File: tb/tb_dc_dw_weight_update.sv
// tb_dc_dw_weight_update
// Directed self-checking bench for dc_dw_weight_update with hand-computed
// expected rows (data_size 8, size 3, lr_shift 3).
module tb_dc_dw_weight_update;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dc_dw_weight_update_if bus ();

    dc_dw_weight_update dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [23:0] p(input int a, input int b, input int c);
        p = {a[7:0], b[7:0], c[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.dc_dw_stream      = 24'h0;
        bus.dc_dw_valid       = 1'b0;
        bus.dc_dw_layer_index = 33'd0;
        bus.commit            = 1'b0;
        bus.weight_read       = 1'b0;
        bus.weight_read_layer = 33'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic send_row(input int layer, input int a, input int b, input int c);
        bus.dc_dw_valid       = 1'b1;
        bus.dc_dw_layer_index = 33'(layer);
        bus.dc_dw_stream      = p(a, b, c);
        tick();
        bus.dc_dw_valid = 1'b0;
    endtask

    // Count remaining busy cycles with a hard bound.
    task automatic wait_busy(input string tag, input int exp);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (bus.busy !== 1'b1) break;
            cnt++;
            tick();
        end
        chk(tag, 32'(cnt), 32'(exp));
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        wait_busy("apply_len", 12);
    endtask

    // weight_read seen at edge k: valid after k+1..k+3, low after k+4.
    task automatic read_layer(input int layer, input logic [23:0] r0,
                              input logic [23:0] r1, input logic [23:0] r2);
        bus.weight_read       = 1'b1;
        bus.weight_read_layer = 33'(layer);
        tick();
        bus.weight_read = 1'b0;
        chk("rd_valid_t1", 32'(bus.weight_valid), 32'd1 - 32'd1);
        chk("rd_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("rd_valid_r0", 32'(bus.weight_valid), 32'd1);
        chk("rd_row0", 32'(bus.weight_stream), 32'(r0));
        tick();
        chk("rd_valid_r1", 32'(bus.weight_valid), 32'd1);
        chk("rd_row1", 32'(bus.weight_stream), 32'(r1));
        tick();
        chk("rd_valid_r2", 32'(bus.weight_valid), 32'd1);
        chk("rd_row2", 32'(bus.weight_stream), 32'(r2));
        tick();
        chk("rd_valid_end", 32'(bus.weight_valid), 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_stream", 32'(bus.weight_stream), 32'd0);
        chk("rst_valid", 32'(bus.weight_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_drop", 32'(bus.drop_err), 32'd0);

        // Basic update on layer 1
        send_row(1, 16, 8, -24);
        send_row(1, 0, 0, 0);
        send_row(1, 0, 0, 0);
        do_commit();
        read_layer(1, p(-2, -1, 3), p(0, 0, 0), p(0, 0, 0));
        read_layer(0, p(0, 0, 0), p(0, 0, 0), p(0, 0, 0));
        chk("basic_drop", 32'(bus.drop_err), 32'd0);

        // Saturation: gradient clamps at 127, weight clamps at -128
        send_row(0, 127, 0, 0);
        send_row(0, 0, 0, 0);
        send_row(0, 0, 0, 0);
        send_row(0, 127, 0, 0);
        do_commit();
        read_layer(0, p(-15, 0, 0), p(0, 0, 0), p(0, 0, 0));
        send_row(0, 127, 0, 0);
        do_commit();
        read_layer(0, p(-30, 0, 0), p(0, 0, 0), p(0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            send_row(0, 127, 0, 0);
            do_commit();
        end
        read_layer(0, p(-128, 0, 0), p(0, 0, 0), p(0, 0, 0));
        read_layer(1, p(-2, -1, 3), p(0, 0, 0), p(0, 0, 0));
        chk("sat_drop", 32'(bus.drop_err), 32'd0);

        // Requests during APPLY are dropped
        send_row(2, 40, -40, 8);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        tick();
        tick();
        bus.commit            = 1'b1;
        bus.dc_dw_valid       = 1'b1;
        bus.dc_dw_layer_index = 33'd2;
        bus.dc_dw_stream      = p(64, 64, 64);
        bus.weight_read       = 1'b1;
        bus.weight_read_layer = 33'd0;
        tick();
        idle_inputs();
        chk("apply_drop_err", 32'(bus.drop_err), 32'd1);
        wait_busy("apply_rest", 9);
        chk("apply_no_read", 32'(bus.weight_valid), 32'd0);
        read_layer(2, p(-5, 5, -1), p(0, 0, 0), p(0, 0, 0));
        do_commit();
        read_layer(2, p(-5, 5, -1), p(0, 0, 0), p(0, 0, 0));

        // Out-of-range row in IDLE
        do_reset();
        chk("rst2_drop", 32'(bus.drop_err), 32'd0);
        send_row(7, 1, 1, 1);
        chk("row_oob_drop", 32'(bus.drop_err), 32'd1);

        // Out-of-range readout request
        do_reset();
        bus.weight_read       = 1'b1;
        bus.weight_read_layer = 33'd5;
        tick();
        bus.weight_read = 1'b0;
        chk("rd_oob_drop", 32'(bus.drop_err), 32'd1);
        chk("rd_oob_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("rd_oob_valid", 32'(bus.weight_valid), 32'd0);

        // commit and weight_read together: commit wins
        do_reset();
        bus.commit            = 1'b1;
        bus.weight_read       = 1'b1;
        bus.weight_read_layer = 33'd0;
        tick();
        idle_inputs();
        chk("both_drop", 32'(bus.drop_err), 32'd1);
        wait_busy("both_apply_len", 12);
        chk("both_no_read", 32'(bus.weight_valid), 32'd0);

        // Reset in the middle of APPLY
        do_reset();
        send_row(1, 16, 8, -24);
        do_commit();
        send_row(1, 16, 8, -24);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy_before", 32'(bus.busy), 32'd1);
        do_reset();
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_drop", 32'(bus.drop_err), 32'd0);
        read_layer(1, p(0, 0, 0), p(0, 0, 0), p(0, 0, 0));
        read_layer(0, p(0, 0, 0), p(0, 0, 0), p(0, 0, 0));

        // Optional lane clipping
        send_row(0, 100, -100, 5);
        do_commit();
`ifdef DC_DW_GRAD_CLIP_EN
        read_layer(0, p(-4, 4, 0), p(0, 0, 0), p(0, 0, 0));
`else
        read_layer(0, p(-12, 13, 0), p(0, 0, 0), p(0, 0, 0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
